// File: rtl/occ_pkg.sv
// Shared types and default sizing for the on-chip clock controller.
// Holds the controller state enum and the default parameter set.
package occ_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    PULSE,
    DONE
  } occ_state_t;

  localparam int OCC_NUM_CH      = 4;
  localparam int OCC_MAX_PULSES  = 8;
  localparam int OCC_DLY_W       = 4;
  localparam int OCC_SYNC_STAGES = 2;

endpackage

// File: rtl/occ_sync.sv
// Scan-enable synchroniser into fclk with falling-edge detect.
// Ports: fclk, rst (sync, high), se (async) -> se_s, se_fall.
module occ_sync
  import occ_pkg::*;
#(
  parameter int SYNC_STAGES = OCC_SYNC_STAGES
) (
  input  logic fclk,
  input  logic rst,
  input  logic se,
  output logic se_s,
  output logic se_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   se_d;

  // Reset to 1: the chain looks like "shifting",
  // so reset release can never fake a capture edge.
  always_ff @(posedge fclk) begin
    if (rst) begin
      sync_q <= '1;
      se_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], se};
      se_d   <= se_s;
    end
  end

  assign se_s    = sync_q[SYNC_STAGES-1];
  assign se_fall = se_d & ~se_s;

endmodule

// File: rtl/occ_pulse_ctrl.sv
// OCC core: launch delay then N at-speed clock-enable pulses per capture.
// Ports: fclk, rst, test_m, se, ch_mask, pulse_cnt, launch_dly -> clk_en, busy, done.
module occ_pulse_ctrl
  import occ_pkg::*;
#(
  parameter int NUM_CH      = OCC_NUM_CH,
  parameter int MAX_PULSES  = OCC_MAX_PULSES,
  parameter int DLY_W       = OCC_DLY_W,
  parameter int SYNC_STAGES = OCC_SYNC_STAGES,
  localparam int CW = $clog2(MAX_PULSES + 1)
) (
  input  logic              fclk,
  input  logic              rst,
  input  logic              test_m,
  input  logic              se,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [CW-1:0]     pulse_cnt,
  input  logic [DLY_W-1:0]  launch_dly,
  output logic [NUM_CH-1:0] clk_en,
  output logic              busy,
  output logic              done
);

  localparam logic [CW-1:0]    PMAX = CW'(MAX_PULSES);
  localparam logic [CW-1:0]    PONE = CW'(1);
  localparam logic [DLY_W-1:0] DONE_ = DLY_W'(1);

  occ_state_t        state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CW-1:0]     pcnt_q, pcnt_d;
  logic [DLY_W-1:0]  dcnt_q, dcnt_d;
  logic [CW-1:0]     pcnt_in;
  logic [NUM_CH-1:0] clk_en_d;
  logic              busy_d, done_d;
  logic              se_s, se_fall;

  occ_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .fclk   (fclk),
    .rst    (rst),
    .se     (se),
    .se_s   (se_s),
    .se_fall(se_fall)
  );

  assign pcnt_in = (pulse_cnt > PMAX) ? PMAX : pulse_cnt;

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      pcnt_q  <= '0;
      dcnt_q  <= '0;
      clk_en  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pcnt_q  <= pcnt_d;
      dcnt_q  <= dcnt_d;
      clk_en  <= clk_en_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    pcnt_d  = pcnt_q;
    dcnt_d  = dcnt_q;
    if (!test_m) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (se_fall) begin
            mask_d  = ch_mask;
            pcnt_d  = pcnt_in;
            dcnt_d  = launch_dly;
            state_d = (pcnt_in == '0) ? DONE : DELAY;
          end
        end
        DELAY: begin
          if (se_s) begin
            state_d = IDLE;
          end else if (dcnt_q > DONE_) begin
            dcnt_d = dcnt_q - 1'b1;
          end else begin
            // zero delay still spends one cycle here
            dcnt_d  = '0;
            state_d = PULSE;
          end
        end
        PULSE: begin
          if (se_s) begin
            state_d = IDLE;
          end else begin
            if (pcnt_q != '0) pcnt_d = pcnt_q - 1'b1;
            if (pcnt_q <= PONE) state_d = DONE;
          end
        end
        DONE: begin
          if (se_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs registered from next state so they
  // line up with the state they describe.
  always_comb begin
    clk_en_d = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    if (!test_m) begin
      clk_en_d = '1;
    end else begin
      if (state_d == PULSE) clk_en_d = mask_d;
      busy_d = (state_d == DELAY) || (state_d == PULSE);
      done_d = (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_occ_pulse_ctrl.sv
// Scoreboard bench for occ_pulse_ctrl.
// Per-cycle expected outputs queued by stimulus, popped on negedge.
module tb_occ_pulse_ctrl;

  logic       fclk = 1'b0;
  logic       rst;
  logic       test_m;
  logic       se;
  logic [3:0] ch_mask;
  logic [3:0] pulse_cnt;
  logic [3:0] launch_dly;
  logic [3:0] clk_en;
  logic       busy;
  logic       done;

  int n_chk = 0;
  int n_err = 0;

  logic [5:0] exp_q[$];
  string      tag_q[$];

  always #5 fclk = ~fclk;

  occ_pulse_ctrl dut (
    .fclk      (fclk),
    .rst       (rst),
    .test_m    (test_m),
    .se        (se),
    .ch_mask   (ch_mask),
    .pulse_cnt (pulse_cnt),
    .launch_dly(launch_dly),
    .clk_en    (clk_en),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag,
                     input logic [5:0] obs,
                     input logic [5:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got clk_en/busy/done=%b_%b_%b want %b_%b_%b",
               tag, obs[5:2], obs[1], obs[0],
               exp[5:2], exp[1], exp[0]);
    end
  endtask

  always @(negedge fclk) begin
    if (exp_q.size() > 0) begin
      chk(tag_q.pop_front(), {clk_en, busy, done},
          exp_q.pop_front());
    end
  end

  // Expect (c,b,d) for the current cycle, then advance.
  task automatic step(input logic [3:0] c, input logic b,
                      input logic d, input string tag);
    exp_q.push_back({c, b, d});
    tag_q.push_back(tag);
    @(posedge fclk);
    #1;
  endtask

  // se falls in cycle 0; with 2 sync stages E is cycle 2.
  task automatic window(input logic [3:0] m, input int n,
                        input int d, input string tag);
    int np;
    int dm;
    np = (n > 8) ? 8 : n;
    dm = (d == 0) ? 1 : d;
    ch_mask    = m;
    pulse_cnt  = 4'(n);
    launch_dly = 4'(d);
    se         = 1'b0;
    repeat (3) step(4'h0, 1'b0, 1'b0, {tag, "_idle"});
    ch_mask    = 4'($urandom);
    pulse_cnt  = 4'($urandom);
    launch_dly = 4'($urandom);
    if (np != 0) begin
      repeat (dm) step(4'h0, 1'b1, 1'b0, {tag, "_dly"});
      repeat (np) step(m, 1'b1, 1'b0, {tag, "_pulse"});
    end
    repeat (2) step(4'h0, 1'b0, 1'b1, {tag, "_done"});
    se = 1'b1;
    repeat (3) step(4'h0, 1'b0, 1'b1, {tag, "_hold"});
    repeat (2) step(4'h0, 1'b0, 1'b0, {tag, "_back"});
  endtask

  initial begin
    rst        = 1'b1;
    test_m     = 1'b1;
    se         = 1'b1;
    ch_mask    = 4'h0;
    pulse_cnt  = 4'h0;
    launch_dly = 4'h0;
    repeat (2) @(posedge fclk);
    #1;
    repeat (2) step(4'h0, 1'b0, 1'b0, "reset");
    rst = 1'b0;
    repeat (4) step(4'h0, 1'b0, 1'b0, "rel");

    window(4'hF, 2, 0, "t2");
    window(4'h5, 3, 5, "t3");
    window(4'hA, 15, 2, "clamp");
    window(4'h3, 0, 3, "zero");

    // abort after first of four pulses
    ch_mask    = 4'hF;
    pulse_cnt  = 4'd4;
    launch_dly = 4'd0;
    se         = 1'b0;
    repeat (2) step(4'h0, 1'b0, 1'b0, "ab_idle");
    se = 1'b1;
    step(4'h0, 1'b0, 1'b0, "ab_e");
    step(4'h0, 1'b1, 1'b0, "ab_dly");
    step(4'hF, 1'b1, 1'b0, "ab_p1");
    repeat (4) step(4'h0, 1'b0, 1'b0, "ab_idle2");
    window(4'hF, 4, 0, "restart");

    // functional mode entered mid-DELAY
    ch_mask    = 4'hF;
    pulse_cnt  = 4'd3;
    launch_dly = 4'd5;
    se         = 1'b0;
    repeat (3) step(4'h0, 1'b0, 1'b0, "tm_idle");
    step(4'h0, 1'b1, 1'b0, "tm_dly");
    test_m = 1'b0;
    se     = 1'b1;
    step(4'h0, 1'b1, 1'b0, "tm_dly2");
    repeat (3) step(4'hF, 1'b0, 1'b0, "tm_func");
    test_m = 1'b1;
    step(4'hF, 1'b0, 1'b0, "tm_func2");
    repeat (3) step(4'h0, 1'b0, 1'b0, "tm_back");

    // reset mid-PULSE
    ch_mask    = 4'hF;
    pulse_cnt  = 4'd8;
    launch_dly = 4'd0;
    se         = 1'b0;
    repeat (3) step(4'h0, 1'b0, 1'b0, "rs_idle");
    step(4'h0, 1'b1, 1'b0, "rs_dly");
    step(4'hF, 1'b1, 1'b0, "rs_p1");
    rst = 1'b1;
    se  = 1'b1;
    step(4'hF, 1'b1, 1'b0, "rs_p2");
    rst = 1'b0;
    repeat (5) step(4'h0, 1'b0, 1'b0, "rs_clr");

    @(negedge fclk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: got %0d left want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
